mc_control_fsm: RTL

//  Multi-cycle control unit; successor to the single-cycle decoder. Sequences each instruction through IF/ID/EXE/MEM/WB.

---
 rtl/mc_pkg.sv | 62 ++++++
 rtl/mc_decode.sv | 53 +++++
 rtl/mc_control_fsm.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle control unit.
//   - state_e      : FSM state codes, also exported on the 'state' port
//   - instr_class_e: coarse instruction class produced by mc_decode
//   - OP_*         : 6-bit opcode values
//   - ALU_*        : ALUOp function codes driven to the datapath ALU
package mc_pkg;

  localparam int OP_W     = 6;
  localparam int ALU_OP_W = 3;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b110,
    S_ERR  = 3'b111
  } state_e;

  typedef enum logic [3:0] {
    CLS_R,
    CLS_I,
    CLS_LW,
    CLS_SW,
    CLS_BR,
    CLS_J,
    CLS_JR,
    CLS_JAL,
    CLS_HALT,
    CLS_ILL
  } instr_class_e;

  localparam logic [OP_W-1:0] OP_ADD   = 6'b000000;
  localparam logic [OP_W-1:0] OP_SUB   = 6'b000001;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b000010;
  localparam logic [OP_W-1:0] OP_AND   = 6'b010000;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b010001;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b010010;
  localparam logic [OP_W-1:0] OP_XORI  = 6'b010011;
  localparam logic [OP_W-1:0] OP_SLL   = 6'b011000;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b100110;
  localparam logic [OP_W-1:0] OP_SLT   = 6'b100111;
  localparam logic [OP_W-1:0] OP_SW    = 6'b110000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b110001;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b110100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b110101;
  localparam logic [OP_W-1:0] OP_BLTZ  = 6'b110110;
  localparam logic [OP_W-1:0] OP_J     = 6'b111000;
  localparam logic [OP_W-1:0] OP_JR    = 6'b111001;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b111010;
  localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_OP_W-1:0] ALU_SLL = 3'b010;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b100;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b110;
  localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'b111;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: purely combinational decode of the latched opcode.
//   op        in  OP_W      latched opcode (op_q of the FSM)
//   cls       out           instruction class
//   alu_op    out ALU_OP_W  ALU function
//   alu_src_a out 1         1 selects shift amount (sll only)
//   alu_src_b out 1         1 selects the extended immediate
//   ext_sel   out 1         1 sign-extend, 0 zero-extend (logical immediates)
//   reg_dst   out 2         00 $31, 01 rt, 10 rd
//   legal     out 1         opcode is recognised
import mc_pkg::*;

module mc_decode (
  input  logic [OP_W-1:0]     op,
  output instr_class_e        cls,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alu_src_a,
  output logic                alu_src_b,
  output logic                ext_sel,
  output logic [1:0]          reg_dst,
  output logic                legal
);

  always_comb begin
    cls       = CLS_ILL;
    alu_op    = ALU_ADD;
    alu_src_a = 1'b0;
    alu_src_b = 1'b0;
    ext_sel   = 1'b1;
    reg_dst   = 2'b01;
    legal     = 1'b1;
    case (op)
      OP_ADD:   begin cls = CLS_R; reg_dst = 2'b10; end
      OP_SUB:   begin cls = CLS_R; reg_dst = 2'b10; alu_op = ALU_SUB; end
      OP_AND:   begin cls = CLS_R; reg_dst = 2'b10; alu_op = ALU_AND; end
      OP_SLT:   begin cls = CLS_R; reg_dst = 2'b10; alu_op = ALU_SLT; end
      OP_SLL:   begin cls = CLS_R; reg_dst = 2'b10; alu_op = ALU_SLL; alu_src_a = 1'b1; end
      OP_ADDIU: begin cls = CLS_I; alu_src_b = 1'b1; end
      OP_ANDI:  begin cls = CLS_I; alu_src_b = 1'b1; alu_op = ALU_AND; ext_sel = 1'b0; end
      OP_ORI:   begin cls = CLS_I; alu_src_b = 1'b1; alu_op = ALU_OR;  ext_sel = 1'b0; end
      OP_XORI:  begin cls = CLS_I; alu_src_b = 1'b1; alu_op = ALU_XOR; ext_sel = 1'b0; end
      OP_SLTI:  begin cls = CLS_I; alu_src_b = 1'b1; alu_op = ALU_SLT; end
      OP_LW:    begin cls = CLS_LW; alu_src_b = 1'b1; end
      OP_SW:    begin cls = CLS_SW; alu_src_b = 1'b1; end
      OP_BEQ, OP_BNE, OP_BLTZ: begin cls = CLS_BR; alu_op = ALU_SUB; end
      OP_J:     cls = CLS_J;
      OP_JR:    cls = CLS_JR;
      OP_JAL:   begin cls = CLS_JAL; reg_dst = 2'b00; end
      OP_HALT:  cls = CLS_HALT;
      default:  legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle control unit (IF/ID/EXE/MEM/WB).
//   CLK, Reset            clock (rising edge), async active-high reset
//   Opcode                opcode from instruction memory, latched in IF
//   zero, sign            ALU flags for branch resolution in EXE
//   mem_ready             data memory access completes this cycle
//   PCWre..WrRegDSrc      datapath enables/selects
//   RegDst, PCSrc, ALUOp  datapath selects / ALU function
//   nRD, nWR              active-low data memory strobes
//   state                 current state code
//   err                   sticky illegal-opcode / memory-timeout flag
//   retired, cycles       performance counters, wrap around
import mc_pkg::*;

module mc_control_fsm #(
  parameter int OPW         = 6,
  parameter int ALUOPW      = 3,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [OPW-1:0]    Opcode,
  input  logic              zero,
  input  logic              sign,
  input  logic              mem_ready,
  output logic              PCWre,
  output logic              IRWre,
  output logic              RegWre,
  output logic              ALUSrcA,
  output logic              ALUSrcB,
  output logic              DBDataSrc,
  output logic              ExtSel,
  output logic              WrRegDSrc,
  output logic [1:0]        RegDst,
  output logic [1:0]        PCSrc,
  output logic [ALUOPW-1:0] ALUOp,
  output logic              nRD,
  output logic              nWR,
  output logic [2:0]        state,
  output logic              err,
  output logic [CNT_W-1:0]  retired,
  output logic [CNT_W-1:0]  cycles
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [OPW-1:0]      op_q, op_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic [CNT_W-1:0]    cycles_q, cycles_d;

  instr_class_e        dec_cls;
  logic [ALU_OP_W-1:0] dec_alu_op;
  logic                dec_legal;
  logic [1:0]          dec_reg_dst;
  logic                br_taken;

  mc_decode u_decode (
    .op        (OP_W'(op_q)),
    .cls       (dec_cls),
    .alu_op    (dec_alu_op),
    .alu_src_a (ALUSrcA),
    .alu_src_b (ALUSrcB),
    .ext_sel   (ExtSel),
    .reg_dst   (dec_reg_dst),
    .legal     (dec_legal)
  );

  assign ALUOp   = ALUOPW'(dec_alu_op);
  assign RegDst  = dec_reg_dst;
  assign state   = state_q;
  assign err     = err_q;
  assign retired = retired_q;
  assign cycles  = cycles_q;

  assign br_taken = ((OP_W'(op_q) == OP_BEQ)  &&  zero) ||
                    ((OP_W'(op_q) == OP_BNE)  && !zero) ||
                    ((OP_W'(op_q) == OP_BLTZ) &&  sign);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IF;
      op_q      <= '0;
      wait_q    <= '0;
      err_q     <= 1'b0;
      retired_q <= '0;
      cycles_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      err_q     <= err_d;
      retired_q <= retired_d;
      cycles_q  <= cycles_d;
    end
  end

  // Opcode is only sampled in IF so later states never see Opcode changes.
  always_comb begin
    op_d      = (state_q == S_IF) ? Opcode : op_q;
    err_d     = err_q | (state_d == S_ERR);
    retired_d = retired_q + CNT_W'(PCWre);
    cycles_d  = cycles_q + CNT_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    RegWre    = 1'b0;
    DBDataSrc = 1'b0;
    WrRegDSrc = 1'b1;
    PCSrc     = 2'b00;
    nRD       = 1'b1;
    nWR       = 1'b1;
    unique case (state_q)
      S_IF: begin
        IRWre   = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        if (!dec_legal) begin
          state_d = S_ERR;
        end else begin
          unique case (dec_cls)
            CLS_J:    begin PCWre = 1'b1; PCSrc = 2'b11; state_d = S_IF; end
            CLS_JR:   begin PCWre = 1'b1; PCSrc = 2'b10; state_d = S_IF; end
            CLS_JAL: begin
              PCWre     = 1'b1;
              PCSrc     = 2'b11;
              RegWre    = 1'b1;
              WrRegDSrc = 1'b0;
              state_d   = S_IF;
            end
            CLS_HALT: state_d = S_HALT;
            default:  state_d = S_EXE;
          endcase
        end
      end
      S_EXE: begin
        wait_d = '0;
        if (dec_cls == CLS_BR) begin
          PCWre   = 1'b1;
          PCSrc   = br_taken ? 2'b01 : 2'b00;
          state_d = S_IF;
        end else if (dec_cls == CLS_LW || dec_cls == CLS_SW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      // The strobe stays low for every waiting cycle; wait_q counts the
      // cycles already spent without ready so the last allowed one errs out.
      S_MEM: begin
        if (dec_cls == CLS_SW) nWR = 1'b0;
        else                   nRD = 1'b0;
        if (mem_ready) begin
          wait_d = '0;
          if (dec_cls == CLS_SW) begin
            PCWre   = 1'b1;
            state_d = S_IF;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = S_ERR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        RegWre    = 1'b1;
        PCWre     = 1'b1;
        DBDataSrc = (dec_cls == CLS_LW);
        state_d   = S_IF;
      end
      S_HALT:  state_d = S_HALT;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

endmodule
